// File: rtl/upd_wub_rd_ctrl_pkg.sv
// Shared LSTM constants and the state encoding for the W/U/b update read controller.
package upd_wub_rd_ctrl_pkg;

   localparam int unsigned ADDR_WIDTH = 12;
   localparam int unsigned NUM_CELL   = 8;
   localparam int unsigned NUM_INPUT  = 53;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/upd_wub_rd_ctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear; shifts on every clock edge.
module delay_line #(
   parameter int unsigned WIDTH = 13,
   parameter int unsigned DEPTH = 7
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/upd_wub_rd_ctrl.sv
// Read-address sequencer for one parameter-update pass; write-back strobes are the reads
// replayed LATENCY cycles later to line up with the update datapath.
module upd_wub_rd_ctrl #(
   parameter int unsigned ADDR_WIDTH = upd_wub_rd_ctrl_pkg::ADDR_WIDTH,
   parameter int unsigned NUM_CELL   = upd_wub_rd_ctrl_pkg::NUM_CELL,
   parameter int unsigned NUM_INPUT  = upd_wub_rd_ctrl_pkg::NUM_INPUT,
   parameter int unsigned LATENCY    = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  i_hold,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic                  o_wr_en,
   output logic                  o_busy,
   output logic                  o_done
);

   import upd_wub_rd_ctrl_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_CELL * NUM_INPUT - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      rd_en_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Address 0 is issued on the same edge that leaves IDLE.
            if (start) begin
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               cnt_d     = (LastAddr == '0) ? '0 : ADDR_WIDTH'(1);
               state_d   = (LastAddr == '0) ? StDrain : StRun;
            end
         end
         StRun: begin
            if (!i_hold) begin
               rd_en_d   = 1'b1;
               rd_addr_d = cnt_q;
               if (cnt_q == LastAddr) begin
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         StDrain: begin
            if (wr_en && (wr_addr == LastAddr)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d == StRun) || (state_d == StDrain);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // The address field rides alongside the strobe, so it holds across bubbles too.
   delay_line #(
      .WIDTH(ADDR_WIDTH + 1),
      .DEPTH(LATENCY)
   ) u_delay_line (
      .clk   (clk),
      .clr   (rst),
      .i_data({rd_en_q, rd_addr_q}),
      .o_data({wr_en, wr_addr})
   );

   assign o_rd_addr = rd_addr_q;
   assign o_rd_en   = rd_en_q;
   assign o_wr_addr = wr_addr;
   assign o_wr_en   = wr_en;
   assign o_busy    = busy_q;
   assign o_done    = done_q;

endmodule

// File: tb/tb_upd_wub_rd_ctrl.sv
// Scoreboard bench: stimulus pushes expected read/write/done events, monitors pop and compare.
module tb_upd_wub_rd_ctrl;

   localparam int AW = 12;

   typedef struct {
      int cyc;
      int addr;
   } ev_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;

   // Index 0: default DUT; index 1: small DUT (LATENCY=1, 1 cell, 2 inputs).
   ev_t rdq[2][$];
   ev_t wrq[2][$];
   int  dnq[2][$];

   logic          rst, start, hold;
   logic [AW-1:0] rd_addr, wr_addr;
   logic          rd_en, wr_en, busy, done;

   logic          rst_s, start_s;
   logic [AW-1:0] rd_addr_s, wr_addr_s;
   logic          rd_en_s, wr_en_s, busy_s, done_s;

   upd_wub_rd_ctrl u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .i_hold   (hold),
      .o_rd_addr(rd_addr),
      .o_rd_en  (rd_en),
      .o_wr_addr(wr_addr),
      .o_wr_en  (wr_en),
      .o_busy   (busy),
      .o_done   (done)
   );

   upd_wub_rd_ctrl #(
      .ADDR_WIDTH(AW),
      .NUM_CELL  (1),
      .NUM_INPUT (2),
      .LATENCY   (1)
   ) u_dut_s (
      .clk      (clk),
      .rst      (rst_s),
      .start    (start_s),
      .i_hold   (1'b0),
      .o_rd_addr(rd_addr_s),
      .o_rd_en  (rd_en_s),
      .o_wr_addr(wr_addr_s),
      .o_wr_en  (wr_en_s),
      .o_busy   (busy_s),
      .o_done   (done_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic mon(input int d, input logic re, input int ra, input logic we, input int wa,
                      input logic dn);
      ev_t e;
      if (re) begin
         if (rdq[d].size() == 0) chk($sformatf("rd_unexpected%0d", d), cyc, -1);
         else begin
            e = rdq[d].pop_front();
            chk($sformatf("rd_cyc%0d", d), cyc, e.cyc);
            chk($sformatf("rd_addr%0d", d), ra, e.addr);
         end
      end
      if (we) begin
         if (wrq[d].size() == 0) chk($sformatf("wr_unexpected%0d", d), cyc, -1);
         else begin
            e = wrq[d].pop_front();
            chk($sformatf("wr_cyc%0d", d), cyc, e.cyc);
            chk($sformatf("wr_addr%0d", d), wa, e.addr);
         end
      end
      if (dn) begin
         if (dnq[d].size() == 0) chk($sformatf("done_unexpected%0d", d), cyc, -1);
         else chk($sformatf("done_cyc%0d", d), cyc, dnq[d].pop_front());
      end
   endtask

   always @(negedge clk) begin
      mon(0, rd_en, int'(rd_addr), wr_en, int'(wr_addr), done);
      mon(1, rd_en_s, int'(rd_addr_s), wr_en_s, int'(wr_addr_s), done_s);
   end

   // Expected events for a pass started at cycle t0; hold cycles t0+h .. t0+h+hl-1 delay
   // every read from address h onward by hl cycles. Events after cycle cut are dropped.
   task automatic push_pass(input int d, input int t0, input int lat, input int n, input int h,
                            input int hl, input int cut);
      int rc;
      for (int k = 0; k < n; k++) begin
         rc = t0 + 1 + k + ((hl > 0 && k >= h) ? hl : 0);
         if (rc <= cut) rdq[d].push_back('{cyc: rc, addr: k});
         if (rc + lat <= cut) wrq[d].push_back('{cyc: rc + lat, addr: k});
         if (k == n - 1 && rc + lat + 1 <= cut) dnq[d].push_back(rc + lat + 1);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_start(input int t);
      wait_cyc(t);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd_en"}, int'(rd_en), 0);
      chk({tag, "_rd_addr"}, int'(rd_addr), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      int t0;
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      rst_s = 1'b1; start_s = 1'b0;
      wait_cyc(2);
      chk_idle("reset");
      rst = 1'b0; rst_s = 1'b0;

      // Plain pass with default parameters.
      t0 = 5;
      push_pass(0, t0, 7, 424, 0, 0, 1 << 30);
      pulse_start(t0);
      wait_cyc(t0 + 1);   chk("busy_first", int'(busy), 1);
      wait_cyc(t0 + 431); chk("busy_last", int'(busy), 1);
      wait_cyc(t0 + 432); chk("busy_at_done", int'(busy), 0);
      wait_cyc(t0 + 433); chk("done_one_cycle", int'(done), 0);
      wait_cyc(t0 + 440);

      // Hold during relative cycles 10..12.
      t0 = cyc;
      push_pass(0, t0, 7, 424, 10, 3, 1 << 30);
      pulse_start(t0);
      wait_cyc(t0 + 10); hold = 1'b1;
      wait_cyc(t0 + 13); hold = 1'b0;
      wait_cyc(t0 + 434); chk("busy_hold_drain", int'(busy), 1);
      wait_cyc(t0 + 440);
      // Hold while idle must not matter.
      hold = 1'b1;

      // Start re-pulsed mid-pass and during drain.
      t0 = cyc;
      push_pass(0, t0, 7, 424, 0, 0, 1 << 30);
      pulse_start(t0);
      hold = 1'b0;
      pulse_start(t0 + 50);
      pulse_start(t0 + 431);
      wait_cyc(t0 + 440);

      // Reset mid-pass, then a fresh pass.
      t0 = cyc;
      push_pass(0, t0, 7, 424, 0, 0, t0 + 100);
      push_pass(0, t0 + 110, 7, 424, 0, 0, 1 << 30);
      pulse_start(t0);
      wait_cyc(t0 + 100); rst = 1'b1; hold = 1'b1; start = 1'b1;
      @(negedge clk);     rst = 1'b0; hold = 1'b0; start = 1'b0;
      chk_idle("midreset");
      pulse_start(t0 + 110);
      chk("restart_addr", int'(rd_addr), 0);
      wait_cyc(t0 + 110 + 440);

      // Start together with reset: nothing happens.
      rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0;
      chk_idle("rst_start");
      repeat (3) @(negedge clk);
      chk_idle("rst_start_later");

      // Small configuration.
      t0 = cyc;
      push_pass(1, t0, 1, 2, 0, 0, 1 << 30);
      wait_cyc(t0);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      wait_cyc(t0 + 3); chk("small_busy", int'(busy_s), 1);
      wait_cyc(t0 + 4); chk("small_busy_done", int'(busy_s), 0);
      wait_cyc(t0 + 10);

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rd_left%0d", d), rdq[d].size(), 0);
         chk($sformatf("wr_left%0d", d), wrq[d].size(), 0);
         chk($sformatf("done_left%0d", d), dnq[d].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
